oe_sort_sequencer: RTL and testbench

// Streaming front-end for the combinational 10-way odd/even asc/dec sort datapath.
// - Collects N nibbles over a valid/ready input port into a frame register and drives them onto the datapath.
// - Waits SETTLE cycles, captures the datapath result, then streams it out over a valid/ready output port with a last flag.
// - Lets a serial producer share one sort instance; the sort ordering rule lives only in the datapath.

---
 rtl/oe_sort_sequencer.sv | 148 ++++++++++++++
 tb/tb_oe_sort_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oe_sort_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : oe_sort_sequencer
// Description : Serial valid/ready front-end for the combinational odd/even
//               sort datapath: loads a frame, waits for settle, streams result.
// Revision    : 1.0 - initial release
// ============================================================================
module oe_sort_sequencer #(
    parameter int N      = 10,
    parameter int W      = 4,
    parameter int SETTLE = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic           in_valid,
    input  logic [W-1:0]   in_data,
    output logic           in_ready,
    output logic [N*W-1:0] srt_in,
    input  logic [N*W-1:0] srt_out,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic           out_last,
    input  logic           out_ready,
    output logic           busy,
    output logic [7:0]     frames_done
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [IW-1:0] c_LAST_IDX    = IW'(N - 1);
    localparam logic [CW-1:0] c_SETTLE_LAST = CW'(SETTLE - 1);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_UNLOAD = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_wr_idx;
    logic [IW-1:0]   r_rd_idx;
    logic [IW-1:0]   w_rd_next;
    logic [CW-1:0]   r_cnt;
    logic [N*W-1:0]  r_result;
    logic            w_accept;
    logic            w_xfer;

    assign w_accept  = in_valid & in_ready & (r_state == ST_LOAD);
    assign w_xfer    = out_valid & out_ready;
    assign w_rd_next = r_rd_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_LOAD;
        end else begin
            case (r_state)
                ST_LOAD:   if (w_accept && r_wr_idx == c_LAST_IDX) w_state_nxt = ST_SETTLE;
                ST_SETTLE: if (r_cnt == c_SETTLE_LAST)             w_state_nxt = ST_UNLOAD;
                ST_UNLOAD: if (w_xfer && r_rd_idx == c_LAST_IDX)   w_state_nxt = ST_LOAD;
                default:   w_state_nxt = ST_LOAD;
            endcase
        end
    end

    // Handshake flags follow the next state so they are valid the cycle the state is.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready    <= 1'b0;
            busy        <= 1'b0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            out_data    <= '0;
            srt_in      <= '0;
            r_result    <= '0;
            frames_done <= '0;
            r_wr_idx    <= '0;
            r_rd_idx    <= '0;
            r_cnt       <= '0;
        end else begin
            in_ready <= (w_state_nxt == ST_LOAD);
            busy     <= (w_state_nxt != ST_LOAD);
            if (flush) begin
                r_wr_idx  <= '0;
                r_rd_idx  <= '0;
                r_cnt     <= '0;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else begin
                case (r_state)
                    ST_LOAD: begin
                        if (w_accept) begin
                            srt_in[int'(r_wr_idx)*W +: W] <= in_data;
                            if (r_wr_idx == c_LAST_IDX) begin
                                r_wr_idx <= '0;
                                r_cnt    <= '0;
                            end else begin
                                r_wr_idx <= r_wr_idx + 1'b1;
                            end
                        end
                    end
                    ST_SETTLE: begin
                        if (r_cnt == c_SETTLE_LAST) begin
                            r_result  <= srt_out;
                            out_valid <= 1'b1;
                            out_data  <= srt_out[W-1:0];
                            out_last  <= (c_LAST_IDX == '0);
                            r_rd_idx  <= '0;
                            r_cnt     <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    ST_UNLOAD: begin
                        if (w_xfer) begin
                            if (r_rd_idx == c_LAST_IDX) begin
                                out_valid   <= 1'b0;
                                out_last    <= 1'b0;
                                r_rd_idx    <= '0;
                                frames_done <= frames_done + 8'd1;
                            end else begin
                                r_rd_idx <= w_rd_next;
                                out_data <= r_result[int'(w_rd_next)*W +: W];
                                out_last <= (w_rd_next == c_LAST_IDX);
                            end
                        end
                    end
                    default: begin
                        r_wr_idx <= '0;
                        r_rd_idx <= '0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_oe_sort_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_oe_sort_sequencer
// Description : Self-checking bench; datapath replaced by a reversing stub.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_oe_sort_sequencer;

    localparam int N = 10;
    localparam int W = 4;

    typedef logic [W-1:0] frame_t [N];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, flush, in_valid, in_ready, out_valid, out_last, out_ready, busy;
    logic [W-1:0]   in_data, out_data;
    logic [N*W-1:0] srt_in, srt_out;
    logic [7:0]     frames_done;

    logic           in_valid3, in_ready3, out_valid3, out_last3, out_ready3, busy3, flush3;
    logic [W-1:0]   in_data3, out_data3;
    logic [N*W-1:0] srt_in3, srt_out3;
    logic [7:0]     frames_done3;

    int n_cmp = 0;
    int n_err = 0;
    int exp_frames = 0;

    for (genvar k = 0; k < N; k++) begin : g_rev
        assign srt_out[k*W +: W]  = srt_in[(N-1-k)*W +: W];
        assign srt_out3[k*W +: W] = srt_in3[(N-1-k)*W +: W];
    end

    oe_sort_sequencer #(.N(N), .W(W), .SETTLE(1)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .srt_in(srt_in), .srt_out(srt_out),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .busy(busy), .frames_done(frames_done)
    );

    oe_sort_sequencer #(.N(N), .W(W), .SETTLE(3)) u_dut3 (
        .clk(clk), .rst(rst), .flush(flush3),
        .in_valid(in_valid3), .in_data(in_data3), .in_ready(in_ready3),
        .srt_in(srt_in3), .srt_out(srt_out3),
        .out_valid(out_valid3), .out_data(out_data3), .out_last(out_last3), .out_ready(out_ready3),
        .busy(busy3), .frames_done(frames_done3)
    );

    function automatic frame_t reversed(input frame_t f);
        frame_t r;
        for (int i = 0; i < N; i++) r[i] = f[N-1-i];
        return r;
    endfunction

    function automatic frame_t rand_frame(input int maxv);
        frame_t f;
        for (int i = 0; i < N; i++) f[i] = W'($urandom_range(maxv, 0));
        return f;
    endfunction

    task automatic send_elem(input logic [W-1:0] v, input int gap_pct);
        int g = 0;
        int t = 0;
        while (gap_pct > 0 && g < 8 && int'($urandom_range(99, 0)) < gap_pct) begin
            in_valid = 1'b0;
            @(negedge clk);
            g++;
        end
        in_valid = 1'b1;
        in_data  = v;
        while (in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, t);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input frame_t f, input int gap_pct);
        for (int i = 0; i < N; i++) send_elem(f[i], gap_pct);
    endtask

    task automatic recv_frame(input frame_t exp, input int exp_lat, input int stall_slot,
                              input int stop_at, input string tag);
        int lat = 0;
        int k = 0;
        int guard = 0;
        int stall = 0;
        out_ready = 1'b1;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        n_cmp++;
        if (lat != exp_lat) begin
            n_err++;
            $display("FAIL %s_latency: got %0d cycles, required %0d", tag, lat, exp_lat);
        end
        while (k < stop_at && guard < 60) begin
            guard++;
            out_ready = !(k == stall_slot && stall < 3);
            if (!out_ready) stall++;
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== exp[k] || out_last !== (k == N-1)) begin
                n_err++;
                $display("FAIL %s_slot%0d: valid=%b ready_in=%b data=%h last=%b, required valid=1 ready_in=0 data=%h last=%b",
                         tag, k, out_valid, in_ready, out_data, out_last, exp[k], (k == N-1));
            end
            if (out_valid === 1'b1 && out_ready) k++;
            @(negedge clk);
        end
        out_ready = 1'b1;
        if (k < stop_at) begin
            n_cmp++; n_err++;
            $display("FAIL %s_unload_timeout: got %0d elements, required %0d", tag, k, stop_at);
        end
        if (stop_at == N) begin
            exp_frames++;
            n_cmp++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || frames_done !== 8'(exp_frames)) begin
                n_err++;
                $display("FAIL %s_done: valid=%b in_ready=%b busy=%b frames=%0d, required 0 1 0 %0d",
                         tag, out_valid, in_ready, busy, frames_done, exp_frames);
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        n_cmp++;
        if ({in_ready, out_valid, out_last, busy, out_data, srt_in, frames_done} !== '0) begin
            n_err++;
            $display("FAIL %s: in_ready=%b out_valid=%b out_last=%b busy=%b out_data=%h srt_in=%h frames=%0d, required all zero",
                     tag, in_ready, out_valid, out_last, busy, out_data, srt_in, frames_done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values("reset_values");
        rst = 1'b0;
        exp_frames = 0;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: in_ready=%b busy=%b, required 1 0", in_ready, busy);
        end
    endtask

    task automatic test_back_to_back();
        frame_t f;
        f = '{4'd2, 4'd1, 4'd6, 4'd7, 4'd4, 4'd4, 4'd9, 4'd8, 4'd2, 4'd3};
        send_frame(f, 0);
        n_cmp++;
        if (in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_settle: in_ready=%b busy=%b out_valid=%b, required 0 1 0", in_ready, busy, out_valid);
        end
        recv_frame(reversed(f), 1, -1, N, "b2b");
    endtask

    task automatic test_gaps_stall();
        frame_t f;
        f = '{4'd2, 4'd1, 4'd6, 4'd7, 4'd4, 4'd4, 4'd9, 4'd8, 4'd2, 4'd3};
        send_frame(f, 50);
        recv_frame(reversed(f), 1, 4, N, "gaps");
    endtask

    task automatic test_ignore_outside_load();
        frame_t f;
        f = rand_frame(14);
        send_frame(f, 0);
        in_valid = 1'b1;
        in_data  = 4'hF;
        recv_frame(reversed(f), 1, 6, N, "hold_f");
        in_valid = 1'b0;
        f = rand_frame(14);
        send_frame(f, 20);
        recv_frame(reversed(f), 1, -1, N, "after_hold");
    endtask

    task automatic test_flush();
        frame_t f;
        for (int i = 0; i < 5; i++) send_elem(W'($urandom_range(15, 0)), 0);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 4'hE;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || frames_done !== 8'(exp_frames)) begin
            n_err++;
            $display("FAIL flush_state: in_ready=%b busy=%b out_valid=%b frames=%0d, required 1 0 0 %0d",
                     in_ready, busy, out_valid, frames_done, exp_frames);
        end
        for (int i = 0; i < N; i++) f[i] = W'(i);
        send_frame(f, 0);
        recv_frame(reversed(f), 1, -1, N, "flush");
    endtask

    task automatic test_mid_reset();
        frame_t f;
        f = rand_frame(15);
        send_frame(f, 0);
        recv_frame(reversed(f), 1, -1, 6, "mid_rst");
        rst = 1'b1;
        @(negedge clk);
        check_reset_values("mid_rst_values");
        rst = 1'b0;
        exp_frames = 0;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL mid_rst_release: in_ready=%b, required 1", in_ready);
        end
        f = rand_frame(15);
        send_frame(f, 30);
        recv_frame(reversed(f), 1, 2, N, "post_rst");
    endtask

    task automatic test_settle3();
        frame_t f;
        frame_t exp;
        frame_t got;
        logic [N-1:0] lasts;
        int t;
        int lat;
        n_cmp++;
        if (frames_done3 !== 8'd0 || in_ready3 !== 1'b1) begin
            n_err++;
            $display("FAIL s3_start: frames=%0d in_ready=%b, required 0 1", frames_done3, in_ready3);
        end
        for (int fr = 0; fr < 256; fr++) begin
            f   = rand_frame(15);
            exp = reversed(f);
            for (int i = 0; i < N; i++) begin
                in_valid3 = 1'b1;
                in_data3  = f[i];
                t = 0;
                while (in_ready3 !== 1'b1 && t < 50) begin
                    @(negedge clk);
                    t++;
                end
                @(negedge clk);
            end
            in_valid3 = 1'b0;
            lat = 0;
            while (out_valid3 !== 1'b1 && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            n_cmp++;
            if (lat != 3) begin
                n_err++;
                $display("FAIL s3_latency frame %0d: got %0d cycles, required 3", fr, lat);
            end
            for (int k = 0; k < N; k++) begin
                t = 0;
                while (out_valid3 !== 1'b1 && t < 20) begin
                    @(negedge clk);
                    t++;
                end
                got[k]   = out_data3;
                lasts[k] = out_last3;
                @(negedge clk);
            end
            n_cmp++;
            if (got != exp || lasts !== {1'b1, {(N-1){1'b0}}} || frames_done3 !== 8'(fr + 1)) begin
                n_err++;
                $display("FAIL s3_frame %0d: data0=%h data9=%h lasts=%b frames=%0d, required data0=%h data9=%h lasts=%b frames=%0d",
                         fr, got[0], got[N-1], lasts, frames_done3, exp[0], exp[N-1],
                         {1'b1, {(N-1){1'b0}}}, 8'(fr + 1));
            end
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        flush3 = 1'b0; in_valid3 = 1'b0; in_data3 = '0; out_ready3 = 1'b1;
        test_reset();
        test_back_to_back();
        test_gaps_stall();
        test_ignore_outside_load();
        test_flush();
        test_mid_reset();
        test_settle3();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
